// File: rtl/apb_rx_ctrl.sv
// APB slave controller for the UART receive datapath.
// Owns the receiver configuration (bit period, data size). It pulses data_read
// when software consumes the RX buffer, and keeps sticky clear-on-read copies
// of the receiver error flags.
module apb_rx_ctrl #(
  parameter logic [13:0] BP_RESET = 14'd10,
  parameter logic [3:0]  DS_RESET = 4'd8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [2:0]  paddr,
  input  logic [7:0]  pwdata,
  output logic [7:0]  prdata,
  output logic        pslverr,
  input  logic [7:0]  rx_data,
  input  logic        data_ready,
  input  logic        overrun_error,
  input  logic        framing_error,
  output logic        data_read,
  output logic [3:0]  data_size,
  output logic [13:0] bit_period
);

  localparam logic [2:0] A_STATUS = 3'd0;
  localparam logic [2:0] A_ERROR  = 3'd1;
  localparam logic [2:0] A_BP_LO  = 3'd2;
  localparam logic [2:0] A_BP_HI  = 3'd3;
  localparam logic [2:0] A_DSIZE  = 3'd4;
  localparam logic [2:0] A_RXDATA = 3'd6;

  localparam logic [13:0] BP_MIN = 14'd2;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  // Decoded view of the current bus cycle
  typedef struct packed {
    logic       acc;     // legal access cycle
    logic       bad;     // access that must be refused
    logic       wr_en;   // accepted write
    logic       rd_en;   // accepted read
    logic [2:0] addr;
    logic [7:0] wdata;
  } apb_req_t;

  state_t      state;
  apb_req_t    req;
  logic        no_setup;
  logic        ds_ok;
  logic        reserved;
  logic        ro_write;
  logic [13:0] bp_cand;
  logic [13:0] bp_wr_val;
  logic [7:0]  rd_mux;
  logic        err_clr;
  logic        rx_consume;
  logic        sticky_fe;
  logic        sticky_oe;

  // APB protocol FSM; a transfer only completes from SETUP
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (psel && !penable) state <= SETUP;
        SETUP:   if (psel && penable)  state <= ACCESS;
        ACCESS:  state <= (psel && !penable) ? SETUP : IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Address decode and refusal rules for the access cycle
  always_comb begin
    no_setup  = (state == IDLE) && psel && penable;
    ds_ok     = (pwdata[3:0] == 4'd5) || (pwdata[3:0] == 4'd7) ||
                (pwdata[3:0] == 4'd8);
    reserved  = (paddr == 3'd5) || (paddr == 3'd7);
    ro_write  = pwrite && ((paddr == A_STATUS) || (paddr == A_ERROR) ||
                           (paddr == A_RXDATA));
    req.acc   = (state == SETUP) && psel && penable;
    req.bad   = reserved || ro_write || (pwrite && (paddr == A_DSIZE) && !ds_ok);
    req.wr_en = req.acc && pwrite && !req.bad;
    req.rd_en = req.acc && !pwrite && !req.bad;
    req.addr  = paddr;
    req.wdata = pwdata;
  end

  // Candidate bit period after a byte-lane write, floored at 2
  always_comb begin
    if (req.addr == A_BP_HI) bp_cand = {req.wdata[5:0], bit_period[7:0]};
    else                     bp_cand = {bit_period[13:8], req.wdata};
    bp_wr_val = (bp_cand < BP_MIN) ? BP_MIN : bp_cand;
  end

  // Read data mux; sticky errors are shown before any clear
  always_comb begin
    case (req.addr)
      A_STATUS: rd_mux = {7'd0, data_ready};
      A_ERROR:  rd_mux = {6'd0, sticky_oe, sticky_fe};
      A_BP_LO:  rd_mux = bit_period[7:0];
      A_BP_HI:  rd_mux = {2'd0, bit_period[13:8]};
      A_DSIZE:  rd_mux = {4'd0, data_size};
      A_RXDATA: rd_mux = rx_data;
      default:  rd_mux = 8'd0;
    endcase
  end

  // Bus response is combinational and only non-zero in the access cycle
  always_comb begin
    prdata     = req.rd_en ? rd_mux : 8'd0;
    pslverr    = (req.acc && req.bad) || no_setup;
    err_clr    = req.rd_en && (req.addr == A_ERROR);
    rx_consume = req.rd_en && (req.addr == A_RXDATA) && data_ready;
  end

  // Configuration registers, updated at the end of an accepted write
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_period <= BP_RESET;
      data_size  <= DS_RESET;
    end else if (req.wr_en) begin
      if (req.addr == A_BP_LO || req.addr == A_BP_HI) bit_period <= bp_wr_val;
      if (req.addr == A_DSIZE)                        data_size  <= req.wdata[3:0];
    end
  end

  // Sticky error flags: a live error in the clearing cycle wins over the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_fe <= 1'b0;
      sticky_oe <= 1'b0;
    end else begin
      sticky_fe <= (sticky_fe && !err_clr) || framing_error;
      sticky_oe <= (sticky_oe && !err_clr) || overrun_error;
    end
  end

  // One-cycle consume pulse following an RXDATA read of a valid byte
  always_ff @(posedge clk) begin
    if (rst) data_read <= 1'b0;
    else     data_read <= rx_consume;
  end

endmodule
